// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and pulse-shape the three board
// buttons (up/down/center) for the level counter, with optional auto-repeat
// on up/down and same-cycle arbitration of the resulting pulses.

// One button channel: 2-FF synchronizer, 4-state debounce FSM, optional
// auto-repeat. 'pulse' is the raw (unarbitrated) press/repeat request.
module btn_chan #(
  parameter int D      = 4,
  parameter int RD     = 0,
  parameter int RP     = 1,
  parameter bit REP_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic other_lvl,
  output logic lvl,
  output logic pulse
);
  localparam int DW   = (D > 2) ? $clog2(D) : 1;
  localparam int RMAX = (RD > RP) ? RD : RP;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam int RD1  = (RD > 0) ? RD - 1 : 0;
  localparam int RP1  = (RP > 0) ? RP - 1 : 0;
  localparam logic [DW-1:0] DLAST = DW'(D - 1);
  localparam logic [RW-1:0] R_DLY = RW'(RD1);
  localparam logic [RW-1:0] R_PER = RW'(RP1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} st_t;

  st_t           state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [RW-1:0] rcnt;
  logic          rfirst;
  logic          s1, sync;
  logic          press, rep_hit;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      sync <= 1'b0;
    end else begin
      s1   <= btn;
      sync <= s1;
    end
  end

  // Debounce state, stable-sample counter and registered debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      lvl   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lvl   <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    end
  end

  // Next-state logic; a press is announced only on PRESS_WAIT -> PRESSED.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press   = 1'b0;
    case (state)
      RELEASED:
        if (sync) begin state_n = PRESS_WAIT; cnt_n = '0; end
      PRESS_WAIT:
        if (!sync) begin
          state_n = RELEASED; cnt_n = '0;
        end else if (cnt == DLAST) begin
          state_n = PRESSED; cnt_n = '0; press = 1'b1;
        end else cnt_n = cnt + DW'(1);
      PRESSED:
        if (!sync) begin state_n = RELEASE_WAIT; cnt_n = '0; end
      RELEASE_WAIT:
        if (sync) begin
          state_n = PRESSED; cnt_n = '0;
        end else if (cnt == DLAST) begin
          state_n = RELEASED; cnt_n = '0;
        end else cnt_n = cnt + DW'(1);
      default: begin state_n = RELEASED; cnt_n = '0; end
    endcase
  end

  // Repeat fires at the initial delay, then at every period while held.
  always_comb begin
    rep_hit = REP_EN && (state == PRESSED) && (rfirst ? (rcnt == R_DLY) : (rcnt == R_PER));
    pulse   = press | (rep_hit & ~other_lvl);
  end

  // Repeat counter: idle and cleared outside PRESSED, reloads on each hit.
  always_ff @(posedge clk) begin
    if (rst || !REP_EN || state != PRESSED) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
    end else if (rep_hit) begin
      rcnt   <= '0;
      rfirst <= 1'b0;
    end else begin
      rcnt   <= rcnt + RW'(1);
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnC,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       center_pulse,
  output logic [2:0] btn_level
);
  localparam int NCH = 3;  // bit order {C, D, U}

  logic [NCH-1:0] pin, raw, lvl, other;

  assign pin   = {btnC, btnD, btnU};
  // Up and down inhibit each other's repeats; center never repeats.
  assign other = {1'b0, lvl[0], lvl[1]};

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      btn_chan #(
        .D      (DEBOUNCE_CYCLES),
        .RD     (REPEAT_DELAY),
        .RP     (REPEAT_PERIOD),
        .REP_EN ((i < 2) && (REPEAT_DELAY > 0))
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .btn       (pin[i]),
        .other_lvl (other[i]),
        .lvl       (lvl[i]),
        .pulse     (raw[i])
      );
    end
  endgenerate

  assign btn_level = lvl;

  // Arbitration: center wins and drops up/down; simultaneous up+down cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_pulse     <= 1'b0;
      down_pulse   <= 1'b0;
      center_pulse <= 1'b0;
    end else begin
      center_pulse <= raw[2];
      up_pulse     <= raw[0] & ~raw[1] & ~raw[2];
      down_pulse   <= raw[1] & ~raw[0] & ~raw[2];
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one instance without repeat (D=4)
// and one with repeat (D=4, delay 10, period 5), sharing all inputs.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnU = 1'b0, btnD = 1'b0, btnC = 1'b0;
  logic u0, d0, c0, u1, d1, c1;
  logic [2:0] l0, l1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .btnC(btnC),
    .up_pulse(u0), .down_pulse(d0), .center_pulse(c0), .btn_level(l0));

  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_r (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .btnC(btnC),
    .up_pulse(u1), .down_pulse(d1), .center_pulse(c1), .btn_level(l1));

  // advance one clock and settle just after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; btnU = 0; btnD = 0; btnC = 0;
    repeat (3) tick;
    total++; if ({u0, d0, c0} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {u0, d0, c0}); end
    total++; if (l0 !== 3'b000) begin bad++; $display("FAIL reset_level: got %b want 000", l0); end
    total++; if ({u1, d1, c1, l1} !== 6'b0) begin bad++; $display("FAIL reset_rep: got %b want 000000", {u1, d1, c1, l1}); end
    rst = 1'b0;
    tick;
    total++; if ({u0, d0, c0, l0} !== 6'b0) begin bad++; $display("FAIL post_reset_idle: got %b want 000000", {u0, d0, c0, l0}); end
  endtask

  task automatic test_press;
    logic [2:0] el;
    btnU = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      tick;
      el = (j >= 6) ? 3'b001 : 3'b000;
      total++; if (u0 !== (j == 6)) begin bad++; $display("FAIL press_up j=%0d: got %b want %b", j, u0, (j == 6)); end
      total++; if (l0 !== el) begin bad++; $display("FAIL press_level j=%0d: got %b want %b", j, l0, el); end
    end
    btnU = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      tick;
      el = (j < 6) ? 3'b001 : 3'b000;
      total++; if (u0 !== 1'b0) begin bad++; $display("FAIL release_up j=%0d: got %b want 0", j, u0); end
      total++; if (l0 !== el) begin bad++; $display("FAIL release_level j=%0d: got %b want %b", j, l0, el); end
    end
  endtask

  task automatic test_bounce;
    logic [7:0] pat;
    pat = 8'b0011_0011;
    for (int j = 0; j < 20; j++) begin
      btnD = (j < 8) ? pat[j] : 1'b0;
      tick;
      total++; if ({d0, l0} !== 4'b0) begin bad++; $display("FAIL bounce j=%0d: got %b want 0000", j, {d0, l0}); end
    end
  endtask

  task automatic test_arbitration;
    btnU = 1'b1; btnC = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick;
      total++; if (c0 !== (j == 6)) begin bad++; $display("FAIL arb_center j=%0d: got %b want %b", j, c0, (j == 6)); end
      total++; if ({u0, d0} !== 2'b00) begin bad++; $display("FAIL arb_up_dropped j=%0d: got %b want 00", j, {u0, d0}); end
    end
    total++; if (l0 !== 3'b101) begin bad++; $display("FAIL arb_level_uc: got %b want 101", l0); end
    btnU = 1'b0; btnC = 1'b0;
    repeat (12) tick;
    btnU = 1'b1; btnD = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick;
      total++; if ({u0, d0, c0} !== 3'b000) begin bad++; $display("FAIL arb_ud_dropped j=%0d: got %b want 000", j, {u0, d0, c0}); end
    end
    total++; if (l0 !== 3'b011) begin bad++; $display("FAIL arb_level_ud: got %b want 011", l0); end
    btnU = 1'b0; btnD = 1'b0;
    repeat (12) tick;
    total++; if (l0 !== 3'b000) begin bad++; $display("FAIL arb_level_idle: got %b want 000", l0); end
  endtask

  task automatic test_repeat;
    int  n, rel;
    logic e;
    n = 0;
    btnU = 1'b1;
    for (int j = 0; j <= 56; j++) begin
      if (j == 45) btnU = 1'b0;  // first low sample at acceptance + 39
      tick;
      rel = j - 6;
      e = (rel == 0) || (rel >= 10 && rel <= 40 && ((rel - 10) % 5) == 0);
      if (u1) n++;
      total++; if (u1 !== e) begin bad++; $display("FAIL repeat_up rel=%0d: got %b want %b", rel, u1, e); end
      total++; if (d1 !== 1'b0) begin bad++; $display("FAIL repeat_down rel=%0d: got %b want 0", rel, d1); end
    end
    total++; if (n != 8) begin bad++; $display("FAIL repeat_count: got %0d want 8", n); end
    total++; if (l1 !== 3'b000) begin bad++; $display("FAIL repeat_release_level: got %b want 000", l1); end
  endtask

  task automatic test_repeat_block;
    int rel;
    logic eu, ed;
    btnU = 1'b1;
    for (int j = 0; j <= 50; j++) begin
      if (j == 18) btnD = 1'b1;  // first sampled at acceptance + 12
      tick;
      rel = j - 6;
      eu = (rel == 0) || (rel == 10) || (rel == 15);
      ed = (rel == 18);
      total++; if (u1 !== eu) begin bad++; $display("FAIL block_up rel=%0d: got %b want %b", rel, u1, eu); end
      total++; if (d1 !== ed) begin bad++; $display("FAIL block_down rel=%0d: got %b want %b", rel, d1, ed); end
    end
    total++; if (l1 !== 3'b011) begin bad++; $display("FAIL block_level: got %b want 011", l1); end
    btnU = 1'b0; btnD = 1'b0;
    repeat (12) tick;
  endtask

  task automatic test_reset_mid;
    logic [2:0] el;
    btnC = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick;
      total++; if (c0 !== (j == 6)) begin bad++; $display("FAIL mid_first_center j=%0d: got %b want %b", j, c0, (j == 6)); end
    end
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      total++; if ({u0, d0, c0, l0} !== 6'b0) begin bad++; $display("FAIL mid_in_reset j=%0d: got %b want 000000", j, {u0, d0, c0, l0}); end
    end
    rst = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      tick;
      el = (j >= 6) ? 3'b100 : 3'b000;
      total++; if (c0 !== (j == 6)) begin bad++; $display("FAIL mid_repulse j=%0d: got %b want %b", j, c0, (j == 6)); end
      total++; if (l0 !== el) begin bad++; $display("FAIL mid_level j=%0d: got %b want %b", j, l0, el); end
    end
    btnC = 1'b0;
    repeat (12) tick;
  endtask

  initial begin
    test_reset;
    test_press;
    test_bounce;
    test_arbitration;
    test_repeat;
    test_repeat_block;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
